wash_phase_timer: RTL and testbench

Timing stage directly upstream of the washer sequencing FSM. It produces that FSM's cycle_timeout and spin_timeout inputs. It times the wash phase (program-selectable length) and the spin phase (fixed length) in coarse ticks derived from clk. Counting freezes while the door is open, and the block exposes remaining time for the front-panel display.

---
 rtl/wash_phase_timer.sv | 138 +++++++++++++
 tb/tb_wash_phase_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Wash/spin phase timer feeding the washer sequencing FSM.
// Counts coarse ticks, freezes while the door is open and reports remaining time.
module wash_phase_timer #(
    parameter int TICK_DIV     = 1000,
    parameter int CNT_W        = 12,
    parameter int QUICK_TICKS  = 300,
    parameter int NORMAL_TICKS = 600,
    parameter int HEAVY_TICKS  = 900,
    parameter int SPIN_TICKS   = 240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wash_en,
    input  logic             spin_en,
    input  logic             door_close,
    input  logic [1:0]       prog_sel,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    // Tick lengths are deliberately truncated to the counter width.
    localparam logic [CNT_W-1:0] QUICK_LD  = CNT_W'(QUICK_TICKS);
    localparam logic [CNT_W-1:0] NORMAL_LD = CNT_W'(NORMAL_TICKS);
    localparam logic [CNT_W-1:0] HEAVY_LD  = CNT_W'(HEAVY_TICKS);
    localparam logic [CNT_W-1:0] SPIN_LD   = CNT_W'(SPIN_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        WASH,
        WASH_DONE,
        SPIN,
        SPIN_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           done_state;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic             paused_nxt;
    logic             phase_en;
    logic [CNT_W-1:0] wash_ld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            remaining <= '0;
            paused    <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            remaining <= rem_nxt;
            paused    <= paused_nxt;
        end
    end

    always_comb begin
        case (prog_sel)
            2'd0:    wash_ld = QUICK_LD;
            2'd2:    wash_ld = HEAVY_LD;
            default: wash_ld = NORMAL_LD;
        endcase
    end

    // Abort outranks everything inside a phase, including a final tick on the same edge.
    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        rem_nxt    = remaining;
        phase_en   = (state == WASH) ? wash_en : spin_en;
        done_state = (state == WASH) ? WASH_DONE : SPIN_DONE;

        case (state)
            IDLE: begin
                presc_nxt = '0;
                rem_nxt   = '0;
                if (wash_en) begin
                    state_nxt = WASH;
                    rem_nxt   = wash_ld;
                end else if (spin_en) begin
                    state_nxt = SPIN;
                    rem_nxt   = SPIN_LD;
                end
            end
            WASH, SPIN: begin
                if (!phase_en) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    rem_nxt   = '0;
                end else if (remaining == '0) begin
                    state_nxt = done_state;
                end else if (door_close) begin
                    if (presc == PRE_MAX) begin
                        presc_nxt = '0;
                        rem_nxt   = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_nxt = done_state;
                        end
                    end else begin
                        presc_nxt = presc + PRE_W'(1);
                    end
                end
            end
            WASH_DONE: begin
                rem_nxt = '0;
                if (!wash_en) begin
                    state_nxt = IDLE;
                end
            end
            SPIN_DONE: begin
                rem_nxt = '0;
                if (!spin_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                presc_nxt = '0;
                rem_nxt   = '0;
            end
        endcase

        paused_nxt = ((state_nxt == WASH) || (state_nxt == SPIN)) && !door_close;
    end

    assign cycle_timeout = (state == WASH_DONE);
    assign spin_timeout  = (state == SPIN_DONE);
    assign busy          = (state == WASH) || (state == SPIN);

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer using small tick parameters.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_wash_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             reset;
    logic             wash_en;
    logic             spin_en;
    logic             door_close;
    logic [1:0]       prog_sel;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;

    int checks;
    int failures;
    int cycles;
    logic saw_cycle_timeout;

    wash_phase_timer #(
        .TICK_DIV    (TICK_DIV),
        .CNT_W       (CNT_W),
        .QUICK_TICKS (3),
        .NORMAL_TICKS(5),
        .HEAVY_TICKS (7),
        .SPIN_TICKS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wash_en      (wash_en),
        .spin_en      (spin_en),
        .door_close   (door_close),
        .prog_sel     (prog_sel),
        .cycle_timeout(cycle_timeout),
        .spin_timeout (spin_timeout),
        .remaining    (remaining),
        .busy         (busy),
        .paused       (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cycle_timeout === 1'b1) saw_cycle_timeout = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int rem, input logic ct, input logic st,
                            input logic bz, input logic pz);
        checkOutput({tag, ".remaining"}, 32'(remaining), 32'(rem));
        checkOutput({tag, ".cycle_timeout"}, 32'(cycle_timeout), 32'(ct));
        checkOutput({tag, ".spin_timeout"}, 32'(spin_timeout), 32'(st));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(bz));
        checkOutput({tag, ".paused"}, 32'(paused), 32'(pz));
    endtask

    // Steps until the selected timeout is high or the budget runs out.
    task automatic waitTimeout(input bit spin, input int max_cycles, output int n);
        n = 0;
        while (((spin ? spin_timeout : cycle_timeout) !== 1'b1) && (n < max_cycles)) begin
            applyStimulus(1);
            n++;
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        saw_cycle_timeout = 1'b0;
        reset             = 1'b0;
        wash_en           = 1'b0;
        spin_en           = 1'b0;
        door_close        = 1'b1;
        prog_sel          = 2'd0;

        applyStimulus(2);
        checkAll("in_reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        applyStimulus(2);
        checkAll("idle", 0, 0, 0, 0, 0);

        // Quick wash: 3 ticks of 4 cycles.
        wash_en = 1'b1;
        applyStimulus(1);
        checkAll("quick_entry", 3, 0, 0, 1, 0);
        applyStimulus(3);
        checkOutput("quick_hold3", 32'(remaining), 32'd3);
        applyStimulus(1);
        checkOutput("quick_rem2", 32'(remaining), 32'd2);
        applyStimulus(4);
        checkOutput("quick_rem1", 32'(remaining), 32'd1);
        applyStimulus(3);
        checkAll("quick_pre_to", 1, 0, 0, 1, 0);
        applyStimulus(1);
        checkAll("quick_timeout", 0, 1, 0, 0, 0);
        applyStimulus(2);
        checkOutput("quick_to_held", 32'(cycle_timeout), 32'd1);
        wash_en = 1'b0;
        applyStimulus(1);
        checkAll("quick_release", 0, 0, 0, 0, 0);

        // Normal wash with a 7-cycle door pause at remaining=3.
        prog_sel = 2'd1;
        wash_en  = 1'b1;
        applyStimulus(1);
        checkOutput("pause_entry", 32'(remaining), 32'd5);
        applyStimulus(8);
        checkOutput("pause_rem3", 32'(remaining), 32'd3);
        door_close = 1'b0;
        applyStimulus(1);
        checkAll("pause_start", 3, 0, 0, 1, 1);
        applyStimulus(6);
        checkAll("pause_held", 3, 0, 0, 1, 1);
        door_close = 1'b1;
        applyStimulus(1);
        checkAll("pause_resume", 3, 0, 0, 1, 0);
        waitTimeout(1'b0, 40, cycles);
        checkOutput("pause_latency", 32'(cycles), 32'd11);
        wash_en = 1'b0;
        applyStimulus(1);

        // Both enables: wash wins, then abort to idle, then spin.
        prog_sel = 2'd0;
        wash_en  = 1'b1;
        spin_en  = 1'b1;
        applyStimulus(1);
        checkAll("prio_wash", 3, 0, 0, 1, 0);
        wash_en = 1'b0;
        applyStimulus(1);
        checkAll("prio_abort", 0, 0, 0, 0, 0);
        applyStimulus(1);
        checkAll("spin_entry", 2, 0, 0, 1, 0);
        saw_cycle_timeout = 1'b0;
        waitTimeout(1'b1, 20, cycles);
        checkOutput("spin_latency", 32'(cycles), 32'd8);
        checkAll("spin_timeout", 0, 0, 1, 0, 0);
        checkOutput("spin_no_cycle_to", 32'(saw_cycle_timeout), 32'd0);
        spin_en = 1'b0;
        applyStimulus(1);
        checkAll("spin_release", 0, 0, 0, 0, 0);

        // Abort coincident with the final spin tick.
        spin_en = 1'b1;
        applyStimulus(1);
        checkOutput("abort_entry", 32'(remaining), 32'd2);
        applyStimulus(7);
        checkAll("abort_pre", 1, 0, 0, 1, 0);
        spin_en = 1'b0;
        applyStimulus(1);
        checkAll("abort_final", 0, 0, 0, 0, 0);
        applyStimulus(2);
        checkOutput("abort_no_to", 32'(spin_timeout), 32'd0);

        // Program decode, mid-wash prog_sel change, spin_en ignored in wash.
        prog_sel = 2'd2;
        wash_en  = 1'b1;
        applyStimulus(1);
        checkOutput("heavy_load", 32'(remaining), 32'd7);
        prog_sel = 2'd0;
        spin_en  = 1'b1;
        applyStimulus(1);
        checkAll("heavy_no_reload", 7, 0, 0, 1, 0);
        wash_en = 1'b0;
        spin_en = 1'b0;
        applyStimulus(1);
        checkOutput("heavy_abort", 32'(busy), 32'd0);
        prog_sel = 2'd3;
        wash_en  = 1'b1;
        applyStimulus(1);
        checkOutput("prog3_load", 32'(remaining), 32'd5);

        // Asynchronous reset mid-wash.
        applyStimulus(2);
        reset = 1'b0;
        #1;
        checkAll("async_reset", 0, 0, 0, 0, 0);
        wash_en = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(2);
        checkAll("post_reset_idle", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
